// File: rtl/text_edit_pkg.sv
// Shared constants and types for the text tile RAM edit controller.
package text_edit_pkg;

  // Tile RAM address packing: {row, col}
  localparam int ROW_W  = 5;
  localparam int COL_W  = 7;
  localparam int ADDR_W = ROW_W + COL_W;
  localparam int CHAR_W = 7;

  // Controller states
  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  // Character codes the decoder cares about
  localparam logic [CHAR_W-1:0] CH_SPACE    = 7'h20;
  localparam logic [CHAR_W-1:0] CH_BS       = 7'h08;
  localparam logic [CHAR_W-1:0] CH_CR       = 7'h0D;
  localparam logic [CHAR_W-1:0] CH_FF       = 7'h0C;
  localparam logic [CHAR_W-1:0] CH_PRINT_LO = 7'h20;
  localparam logic [CHAR_W-1:0] CH_PRINT_HI = 7'h7E;

  // One tile RAM write request
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [CHAR_W-1:0] data;
  } ram_req_t;

  function automatic logic [ADDR_W-1:0] pack_addr(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/text_edit_ctrl_if.sv
// Keyboard handshake, tile RAM write port and cursor outputs of the edit controller.
interface text_edit_ctrl_if;
  import text_edit_pkg::*;

  logic              ascii_valid;
  logic [CHAR_W-1:0] ascii_data;
  logic              ascii_ready;
  logic              clr;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [CHAR_W-1:0] ram_data;
  logic [ROW_W-1:0]  cursor_row;
  logic [COL_W-1:0]  cursor_col;
  logic              cursor_vis;

  // Keyboard front-end / display side
  modport master (
    output ascii_valid, ascii_data, clr,
    input  ascii_ready, ram_we, ram_addr, ram_data, cursor_row, cursor_col, cursor_vis
  );

  // Controller side
  modport slave (
    input  ascii_valid, ascii_data, clr,
    output ascii_ready, ram_we, ram_addr, ram_data, cursor_row, cursor_col, cursor_vis
  );
endinterface

// File: rtl/cursor_blink_timer.sv
// Free-running cursor blink: toggles visibility every BLINK_DIV cycles, restartable.
module cursor_blink_timer #(
  parameter int BLINK_DIV = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic vis
);
  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Count a half-period; a restart shows the cursor and begins a fresh half-period
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      vis <= 1'b1;
    end else if (restart) begin
      cnt <= '0;
      vis <= 1'b1;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      vis <= ~vis;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/text_edit_ctrl.sv
// Text tile RAM sequencer: screen clear sweep, character entry and cursor tracking.
module text_edit_ctrl
  import text_edit_pkg::*;
#(
  parameter int COLS      = 80,
  parameter int ROWS      = 30,
  parameter int FIRST_ROW = 4,
  parameter int BLINK_DIV = 25000000
) (
  input  logic           clk,
  input  logic           reset,
  text_edit_ctrl_if.slave bus
);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(FIRST_ROW);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);

  logic [1:0]       state;
  logic [ROW_W-1:0] swp_row, cur_row;
  logic [COL_W-1:0] swp_col, cur_col;
  logic             swp_end;   // last cell has been strobed; leave CLEAR next cycle
  ram_req_t         req;

  logic             accept;
  logic [ROW_W-1:0] nxt_row, adv_row, ret_row;
  logic [COL_W-1:0] adv_col, ret_col;
  logic [CHAR_W-1:0] ch;
  logic             is_print;

  assign bus.ascii_ready = (state == ST_IDLE);
  // A coincident clear wins over the character, which is left unconsumed
  assign accept   = bus.ascii_valid && bus.ascii_ready && !bus.clr;
  assign ch       = bus.ascii_data;
  assign is_print = (ch >= CH_PRINT_LO) && (ch <= CH_PRINT_HI);

  assign bus.ram_we     = req.we;
  assign bus.ram_addr   = req.addr;
  assign bus.ram_data   = req.data;
  assign bus.cursor_row = cur_row;
  assign bus.cursor_col = cur_col;

  // Cursor step arithmetic: row advance wraps inside the editable area, no scrolling
  always_comb begin
    nxt_row = (cur_row < ROW_LAST) ? cur_row + 5'd1 : ROW_FIRST;
    adv_row = cur_row;
    adv_col = cur_col + 7'd1;
    if (cur_col >= COL_LAST) begin
      adv_row = nxt_row;
      adv_col = '0;
    end
    ret_row = cur_row;
    ret_col = cur_col;
    if (cur_col != '0) begin
      ret_col = cur_col - 7'd1;
    end else if (cur_row > ROW_FIRST) begin
      ret_row = cur_row - 5'd1;
      ret_col = COL_LAST;
    end
  end

  // Main sequencer: sweep, decode and one-cycle write strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_CLEAR;
      swp_row <= ROW_FIRST;
      swp_col <= '0;
      swp_end <= 1'b0;
      cur_row <= ROW_FIRST;
      cur_col <= '0;
      req     <= '0;
    end else begin
      req.we <= 1'b0;
      case (state)
        ST_CLEAR: begin
          if (swp_end) begin
            swp_end <= 1'b0;
            cur_row <= ROW_FIRST;
            cur_col <= '0;
            state   <= ST_IDLE;
          end else begin
            req <= '{we: 1'b1, addr: pack_addr(swp_row, swp_col), data: CH_SPACE};
            if (swp_col == COL_LAST) begin
              swp_col <= '0;
              if (swp_row == ROW_LAST) swp_end <= 1'b1;
              else                     swp_row <= swp_row + 5'd1;
            end else begin
              swp_col <= swp_col + 7'd1;
            end
          end
        end
        ST_IDLE: begin
          if (bus.clr || (accept && ch == CH_FF)) begin
            swp_row <= ROW_FIRST;
            swp_col <= '0;
            swp_end <= 1'b0;
            state   <= ST_CLEAR;
          end else if (accept) begin
            if (is_print) begin
              req     <= '{we: 1'b1, addr: pack_addr(cur_row, cur_col), data: ch};
              cur_row <= adv_row;
              cur_col <= adv_col;
              state   <= ST_WRITE;
            end else if (ch == CH_BS) begin
              req     <= '{we: 1'b1, addr: pack_addr(ret_row, ret_col), data: CH_SPACE};
              cur_row <= ret_row;
              cur_col <= ret_col;
              state   <= ST_WRITE;
            end else if (ch == CH_CR) begin
              cur_row <= nxt_row;
              cur_col <= '0;
            end
          end
        end
        ST_WRITE: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  cursor_blink_timer #(.BLINK_DIV(BLINK_DIV)) u_blink (
    .clk     (clk),
    .reset   (reset),
    .restart (accept),
    .vis     (bus.cursor_vis)
  );
endmodule

// File: tb/tb_text_edit_ctrl.sv
// Directed bench for text_edit_ctrl (80x30, editable rows 4..29, blink divider 4).
module tb_text_edit_ctrl;
  import text_edit_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  text_edit_ctrl_if bus();

  text_edit_ctrl #(.COLS(80), .ROWS(30), .FIRST_ROW(4), .BLINK_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int n;
  logic prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance n clock edges, leaving the sample point 1 time unit after the edge
  task automatic step(input int cyc);
    repeat (cyc) begin @(posedge clk); #1; end
  endtask

  task automatic chk_cur(input string tag, input logic [4:0] row, input logic [6:0] col);
    chk({tag, "_row"}, 32'(bus.cursor_row), 32'(row));
    chk({tag, "_col"}, 32'(bus.cursor_col), 32'(col));
  endtask

  task automatic chk_wr(input string tag, input logic [4:0] row, input logic [6:0] col,
                        input logic [6:0] data);
    logic [11:0] ea;
    ea = {row, col};
    chk({tag, "_we"},   32'(bus.ram_we),   32'd1);
    chk({tag, "_addr"}, 32'(bus.ram_addr), 32'(ea));
    chk({tag, "_data"}, 32'(bus.ram_data), 32'(data));
  endtask

  // present one character once ready is up; returns at the sample point after acceptance
  task automatic send(input logic [6:0] c);
    int w;
    w = 0;
    while (bus.ascii_ready !== 1'b1 && w < 5000) begin step(1); w++; end
    if (w >= 5000) chk("ready_timeout", 32'(w), 32'd0);
    bus.ascii_valid = 1'b1;
    bus.ascii_data  = c;
    step(1);
    bus.ascii_valid = 1'b0;
  endtask

  // follow a full clear sweep, optionally pulsing clr part-way through
  task automatic check_sweep(input string tag, input int clr_at);
    int bad, w;
    logic [11:0] ea;
    bad = 0;
    w = 0;
    while (bus.ram_we !== 1'b1 && w < 10) begin step(1); w++; end
    for (int k = 0; k < 2080; k++) begin
      ea = {5'(4 + k / 80), 7'(k % 80)};
      if (!(bus.ram_we === 1'b1 && bus.ram_addr === ea && bus.ram_data === 7'h20 &&
            bus.ascii_ready === 1'b0)) bad++;
      if (k == clr_at) bus.clr = 1'b1;
      step(1);
      bus.clr = 1'b0;
    end
    chk({tag, "_bad_cells"}, 32'(bad), 32'd0);
    chk({tag, "_we_after"}, 32'(bus.ram_we), 32'd0);
    chk({tag, "_ready_after"}, 32'(bus.ascii_ready), 32'd1);
    chk_cur({tag, "_cursor"}, 5'd4, 7'd0);
  endtask

  // wait for the blink phase to fall 1 -> 0 (blink counter just restarted at 0)
  task automatic wait_vis_fall(input string tag);
    int w;
    w = 0;
    prev = bus.cursor_vis;
    step(1);
    while (!(prev === 1'b1 && bus.cursor_vis === 1'b0) && w < 20) begin
      prev = bus.cursor_vis;
      step(1);
      w++;
    end
    if (w >= 20) chk({tag, "_timeout"}, 32'(w), 32'd0);
  endtask

  initial begin
    bus.ascii_valid = 1'b0;
    bus.ascii_data  = '0;
    bus.clr         = 1'b0;

    // reset state
    #22;
    chk("rst_we",    32'(bus.ram_we),      32'd0);
    chk("rst_ready", 32'(bus.ascii_ready), 32'd0);
    chk("rst_addr",  32'(bus.ram_addr),    32'd0);
    chk("rst_data",  32'(bus.ram_data),    32'd0);
    chk("rst_vis",   32'(bus.cursor_vis),  32'd1);
    chk_cur("rst_cur", 5'd4, 7'd0);

    // power-up sweep with a clr pulse that must be ignored
    @(negedge clk) reset = 1'b1;
    check_sweep("sweep0", 500);

    // blink period of 4 cycles
    wait_vis_fall("blink");
    step(3);
    chk("blink_hold0", 32'(bus.cursor_vis), 32'd0);
    step(1);
    chk("blink_rise", 32'(bus.cursor_vis), 32'd1);
    step(3);
    chk("blink_hold1", 32'(bus.cursor_vis), 32'd1);
    step(1);
    chk("blink_fall", 32'(bus.cursor_vis), 32'd0);

    // printable at (4,0)
    send(7'h41);
    chk_wr("ch41", 5'd4, 7'd0, 7'h41);
    chk_cur("ch41_cur", 5'd4, 7'd1);
    chk("ch41_ready_lo", 32'(bus.ascii_ready), 32'd0);
    step(1);
    chk("ch41_ready_hi", 32'(bus.ascii_ready), 32'd1);
    chk("ch41_we_off", 32'(bus.ram_we), 32'd0);

    // unknown control code is swallowed
    send(7'h01);
    chk("nop_we", 32'(bus.ram_we), 32'd0);
    chk_cur("nop_cur", 5'd4, 7'd1);

    // walk to (29,79) and write the last cell: cursor wraps to (4,0)
    repeat (25) send(CH_CR);
    chk_cur("cr25_cur", 5'd29, 7'd0);
    repeat (79) send(7'h61);
    chk_cur("fill_cur", 5'd29, 7'd79);
    send(7'h7A);
    chk_wr("last", 5'd29, 7'd79, 7'h7A);
    chk_cur("last_cur", 5'd4, 7'd0);

    // CR from (7,33)
    repeat (3) send(CH_CR);
    repeat (33) send(7'h62);
    chk_cur("pre_cr_cur", 5'd7, 7'd33);
    send(CH_CR);
    chk("cr_we", 32'(bus.ram_we), 32'd0);
    chk_cur("cr_cur", 5'd8, 7'd0);

    // form feed clears like clr
    send(CH_FF);
    chk("ff_ready", 32'(bus.ascii_ready), 32'd0);
    check_sweep("sweep_ff", -1);

    // backspace across a row boundary
    send(CH_CR);
    chk_cur("bs_pre_cur", 5'd5, 7'd0);
    send(CH_BS);
    chk_wr("bs_wrap", 5'd4, 7'd79, 7'h20);
    chk_cur("bs_wrap_cur", 5'd4, 7'd79);

    // clr beats a coincident character
    step(1);
    bus.clr = 1'b1;
    bus.ascii_valid = 1'b1;
    bus.ascii_data = 7'h41;
    step(1);
    bus.clr = 1'b0;
    bus.ascii_valid = 1'b0;
    chk("clrv_we", 32'(bus.ram_we), 32'd0);
    chk("clrv_ready", 32'(bus.ascii_ready), 32'd0);
    check_sweep("sweep_clr", -1);

    // backspace at home: blank the home cell, no move
    send(CH_BS);
    chk_wr("bs_home", 5'd4, 7'd0, 7'h20);
    chk_cur("bs_home_cur", 5'd4, 7'd0);

    // accepting a character while hidden forces the cursor visible
    step(1);
    wait_vis_fall("force");
    bus.ascii_valid = 1'b1;
    bus.ascii_data  = 7'h01;
    step(1);
    bus.ascii_valid = 1'b0;
    chk("force_vis", 32'(bus.cursor_vis), 32'd1);
    step(3);
    chk("force_hold", 32'(bus.cursor_vis), 32'd1);
    step(1);
    chk("force_toggle", 32'(bus.cursor_vis), 32'd0);

    // asynchronous reset in the middle of a sweep
    send(CH_FF);
    n = 0;
    while (bus.ram_we !== 1'b1 && n < 10) begin step(1); n++; end
    step(1000);
    chk("mid_addr_pre", 32'(bus.ram_addr), 32'({5'd16, 7'd40}));
    #2 reset = 1'b0;
    #1;
    chk("arst_we",    32'(bus.ram_we),      32'd0);
    chk("arst_ready", 32'(bus.ascii_ready), 32'd0);
    chk("arst_addr",  32'(bus.ram_addr),    32'd0);
    chk("arst_vis",   32'(bus.cursor_vis),  32'd1);
    chk_cur("arst_cur", 5'd4, 7'd0);
    @(negedge clk) reset = 1'b1;
    check_sweep("sweep_rst", -1);

    send(7'h01);
    chk("nop2_we", 32'(bus.ram_we), 32'd0);
    chk_cur("nop2_cur", 5'd4, 7'd0);
    step(1);
    chk("nop2_ready", 32'(bus.ascii_ready), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/text_edit_ctrl.md
Name: text_edit_ctrl

Overview:
Sequencer for the editor's text tile RAM, which the screen text generator reads through the font ROM path. It consumes ASCII characters from the keyboard front-end over a valid/ready handshake and maintains the cursor position. It issues single-cycle write strobes into the tile RAM, including a full-screen clear sweep. It also produces a blinking cursor-visibility flag for the pixel mux.

Parameters:
COLS, 80, text columns per row (640 px / 8 px glyph)
ROWS, 30, text rows (480 px / 16 px glyph)
FIRST_ROW, 4, first editable row; rows 0..FIRST_ROW-1 are reserved for menu/title labels and are never written
BLINK_DIV, 25000000, clk cycles per cursor blink half-period

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (reset=0 resets)
ascii_valid  in  1  character available
ascii_data  in  7  ASCII code
ascii_ready  out  1  controller accepts a character this cycle
clr  in  1  single-cycle clear-screen request
ram_we  out  1  tile RAM write strobe
ram_addr  out  12  {row[4:0], col[6:0]}
ram_data  out  7  character code to write
cursor_row  out  5  current cursor row
cursor_col  out  7  current cursor column
cursor_vis  out  1  cursor blink phase; 1 = draw cursor

Behaviour:
- Reset is asynchronous, active-low: reset=0 puts the design in its reset state immediately, regardless of clk.
- Reset values: state=CLEAR with sweep pointer {FIRST_ROW,0}; cursor=(FIRST_ROW,0); ram_we=0; ram_addr=0; ram_data=0; cursor_vis=1; blink counter=0; ascii_ready=0.
- ascii_ready=1 only in IDLE. Combinational from state.
- FSM states: CLEAR, IDLE, WRITE.
- CLEAR:
  - Each cycle: ram_we=1, ram_data=0x20, ram_addr=sweep pointer.
  - Pointer steps col 0..COLS-1, then next row, from FIRST_ROW to ROWS-1. That is (ROWS-FIRST_ROW)*COLS consecutive strobes (2080 at defaults).
  - After the last cell: cursor=(FIRST_ROW,0), go to IDLE.
  - clr and ascii_valid are ignored in CLEAR.
- IDLE:
  - clr=1 has priority: restart the sweep at {FIRST_ROW,0}, go to CLEAR. A coincident ascii_valid is not accepted (ready drops next cycle).
  - On ascii_valid && ascii_ready, latch ascii_data and decode:
    - 0x20..0x7E (printable): WRITE at cursor with that code; advance cursor.
    - 0x08 (backspace): retreat cursor, then WRITE 0x20 at the new position. Retreat: col>0 → col-1; col==0 && row>FIRST_ROW → (row-1, COLS-1); at (FIRST_ROW,0) → no move.
    - 0x0D (CR): col=0 and advance row. No write; stay IDLE.
    - 0x0C (form feed): same as clr.
    - Any other code: consumed and ignored; no write, no cursor change.
- Advance rule:
  - col<COLS-1 → col+1.
  - Otherwise col=0 and the row advances.
  - Row advance: row<ROWS-1 → row+1; else wrap to FIRST_ROW. There is no scrolling.
- WRITE: exactly one cycle. ram_we=1 with the latched address/data. Return to IDLE.
- Latency and throughput:
  - Accept at cycle N → ram_we at N+1. The cursor outputs show the updated position at N+1.
  - ascii_ready is 0 at N+1 and 1 again at N+2. Maximum rate is one character per 2 cycles.
- ram_we=0 in every cycle not listed above. ram_addr/ram_data are don't-care when ram_we=0.
- Blink:
  - Counter 0..BLINK_DIV-1; cursor_vis toggles on terminal count.
  - Any accepted character forces cursor_vis=1 and counter=0 on the following cycle.
  - Blink runs in all states.
- Widths: row compares use 5 bits, col compares 7 bits. No arithmetic ever produces col≥COLS or row≥ROWS.

Decomposition:
- Package text_edit_pkg holds:
  - state encoding (CLEAR, IDLE, WRITE);
  - character constants CH_SPACE=0x20, CH_BS=0x08, CH_CR=0x0D, CH_FF=0x0C, CH_PRINT_LO=0x20, CH_PRINT_HI=0x7E;
  - address packing widths (ROW_W=5, COL_W=7).
- One sub-module: cursor_blink_timer, containing the counter, toggle and restart input.

Test Plan:
- Reset release → ram_we=1 for 2080 consecutive cycles, addresses {4,0}…{29,79}, data 0x20. ascii_ready rises the cycle after the last strobe; cursor=(4,0).
- From (4,0), send 0x41 → next cycle ram_we=1, addr {4,0}, data 0x41, cursor=(4,1), ascii_ready=0; ready=1 the cycle after.
- Cursor (29,79), send 0x7A → write {29,79}=0x7A, cursor=(4,0). Cursor (7,33), send 0x0D → cursor=(8,0), no ram_we.
- Cursor (5,0), send 0x08 → cursor=(4,79), write 0x20 at {4,79}. Then at (4,0), send 0x08 → write 0x20 at {4,0}, cursor stays (4,0).
- clr pulse mid-sweep ignored. reset=0 asserted at sweep cell 1000 → outputs reset immediately. After release, the sweep restarts at {4,0} and runs the full 2080 cycles. Send 0x01 → consumed with no write.
- BLINK_DIV=4 → cursor_vis toggles every 4 cycles. Accepting a character while vis=0 → vis=1 the next cycle; the next toggle comes 4 cycles later.
